// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared state encoding and default sizing constants for the
//                memory-access pipeline stage and its request timer.
//  Contents    : state_t (IDLE / REQ / RESP), DEFAULT_DATA_WIDTH,
//                DEFAULT_REGADDR_WIDTH, DEFAULT_TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_REGADDR_WIDTH = 3;
    localparam int DEFAULT_TIMEOUT       = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_req_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_timer
//  Description : Counts cycles spent waiting for a memory acknowledge and
//                flags the last permitted cycle.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                clear       - return count to zero
//                enable      - count this cycle (request outstanding)
//                expired     - high during the TIMEOUT-th enabled cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_timer
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    // Saturates at TIMEOUT so the count can never wrap back into range.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Flagged one cycle early: the cycle whose increment reaches TIMEOUT is
    // the last cycle the request stays up.
    assign expired = enable && (count == LAST);

endmodule : mem_req_timer
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM pipeline stage. ALU ops pass straight through; loads and
//                stores stall the pipe, issue one data-memory request, and
//                present the result (or a timeout fault) for one cycle.
//  Ports       : ex_mem_*  - operation from the EX/MEM register
//                dmem_*    - data memory request / response handshake
//                mem_*     - toward the MEM/WB register, plus stall and fault
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int REGADDR_WIDTH = DEFAULT_REGADDR_WIDTH,
    parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_mem_valid,
    input  logic                     ex_mem_reg_write,
    input  logic                     ex_mem_mem_read,
    input  logic                     ex_mem_mem_write,
    input  logic [DATA_WIDTH-1:0]    ex_mem_alu_result,
    input  logic [DATA_WIDTH-1:0]    ex_mem_write_data,
    input  logic [REGADDR_WIDTH-1:0] ex_mem_rd,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [DATA_WIDTH-1:0]    dmem_addr,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    input  logic                     dmem_ack,
    output logic                     mem_stall,
    output logic                     mem_reg_write,
    output logic                     mem_mem_read,
    output logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic [DATA_WIDTH-1:0]    mem_alu_result,
    output logic [REGADDR_WIDTH-1:0] mem_rd,
    output logic                     mem_fault
);

    state_t                   state;
    state_t                   state_next;
    logic [DATA_WIDTH-1:0]    lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [DATA_WIDTH-1:0]    rdata_cap;
    logic [REGADDR_WIDTH-1:0] lat_rd;
    logic                     lat_reg_write;
    logic                     lat_read;
    logic                     fault;
    logic                     timer_expired;
    logic                     mem_op;

    assign mem_op = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);

    mem_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == RESP),
        .enable  (state == REQ),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_read      <= 1'b0;
            rdata_cap     <= '0;
            fault         <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        lat_addr      <= ex_mem_alu_result;
                        lat_wdata     <= ex_mem_write_data;
                        lat_rd        <= ex_mem_rd;
                        lat_reg_write <= ex_mem_reg_write;
                        // Read wins when both kinds are requested.
                        lat_read      <= ex_mem_mem_read;
                    end
                end
                REQ: begin
                    // An ack on the final timer cycle still counts as success.
                    if (dmem_ack) begin
                        rdata_cap <= lat_read ? dmem_rdata : '0;
                        fault     <= 1'b0;
                    end else if (timer_expired) begin
                        rdata_cap <= '0;
                        fault     <= 1'b1;
                    end
                end
                RESP: begin
                    rdata_cap <= '0;
                    fault     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        mem_stall      = 1'b0;
        mem_reg_write  = 1'b0;
        mem_mem_read   = 1'b0;
        mem_read_data  = '0;
        mem_alu_result = '0;
        mem_rd         = '0;
        mem_fault      = 1'b0;

        case (state)
            IDLE: begin
                if (mem_op) begin
                    // Stall immediately so EX/MEM holds while we take the op.
                    mem_stall  = 1'b1;
                    state_next = REQ;
                end else if (ex_mem_valid) begin
                    mem_reg_write  = ex_mem_reg_write;
                    mem_alu_result = ex_mem_alu_result;
                    mem_rd         = ex_mem_rd;
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = ~lat_read;
                dmem_addr  = lat_addr;
                dmem_wdata = lat_wdata;
                mem_stall  = 1'b1;
                if (dmem_ack || timer_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                mem_alu_result = lat_addr;
                mem_rd         = lat_rd;
                mem_read_data  = rdata_cap;
                mem_mem_read   = lat_read & ~fault;
                mem_reg_write  = lat_reg_write & lat_read & ~fault;
                mem_fault      = fault;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // The IDLE passthrough is combinational, so force it quiet in reset.
        if (reset) begin
            dmem_req       = 1'b0;
            dmem_we        = 1'b0;
            dmem_addr      = '0;
            dmem_wdata     = '0;
            mem_stall      = 1'b0;
            mem_reg_write  = 1'b0;
            mem_mem_read   = 1'b0;
            mem_read_data  = '0;
            mem_alu_result = '0;
            mem_rd         = '0;
            mem_fault      = 1'b0;
        end
    end

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Self-checking bench for mem_access_stage: IDLE-cycle vector
//                table plus directed load / store / timeout / reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;
    logic [15:0] ex_mem_alu_result, ex_mem_write_data;
    logic [2:0]  ex_mem_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall, mem_reg_write, mem_mem_read, mem_fault;
    logic [15:0] mem_read_data, mem_alu_result;
    logic [2:0]  mem_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_WIDTH    (16),
        .REGADDR_WIDTH (3),
        .TIMEOUT       (15)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_reg_write  (ex_mem_reg_write),
        .ex_mem_mem_read   (ex_mem_mem_read),
        .ex_mem_mem_write  (ex_mem_mem_write),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_write_data (ex_mem_write_data),
        .ex_mem_rd         (ex_mem_rd),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .mem_stall         (mem_stall),
        .mem_reg_write     (mem_reg_write),
        .mem_mem_read      (mem_mem_read),
        .mem_read_data     (mem_read_data),
        .mem_alu_result    (mem_alu_result),
        .mem_rd            (mem_rd),
        .mem_fault         (mem_fault)
    );

    typedef struct {
        logic        valid;
        logic        rw;
        logic        rd_op;
        logic        wr_op;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [2:0]  rd;
        logic        e_stall;
        logic        e_rw;
        logic [15:0] e_alu;
        logic [2:0]  e_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic rw, input logic rdo, input logic wro,
                          input logic [15:0] alu, input logic [15:0] wd, input logic [2:0] rd);
        ex_mem_valid      = v;
        ex_mem_reg_write  = rw;
        ex_mem_mem_read   = rdo;
        ex_mem_mem_write  = wro;
        ex_mem_alu_result = alu;
        ex_mem_write_data = wd;
        ex_mem_rd         = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        // valid rw rd wr alu wdata rd | stall rw alu rd
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 3'd5, 1'b0, 1'b1, 16'h1234, 3'd5};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h1111, 3'd6, 1'b0, 1'b0, 16'h0000, 3'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h2222, 3'd7, 1'b0, 1'b0, 16'hFFFF, 3'd7};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 3'd3, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h00AA, 3'd1, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h3333, 3'd2, 1'b0, 1'b0, 16'h0000, 3'd0};

        // Reset held with a live ALU op on the inputs: everything must be 0.
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        set_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 3'd5);
        next_cycle();
        @(negedge clk);
        chk("rst_reg_write", mem_reg_write, 0);
        chk("rst_alu", mem_alu_result, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_req", dmem_req, 0);

        // IDLE-cycle vector table, each from a fresh reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_op(vecs[i].valid, vecs[i].rw, vecs[i].rd_op, vecs[i].wr_op,
                   vecs[i].alu, vecs[i].wdata, vecs[i].rd);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].e_stall);
            chk($sformatf("v%0d_reg_write", i), mem_reg_write, vecs[i].e_rw);
            chk($sformatf("v%0d_alu", i), mem_alu_result, vecs[i].e_alu);
            chk($sformatf("v%0d_rd", i), mem_rd, vecs[i].e_rd);
            chk($sformatf("v%0d_mem_read", i), mem_mem_read, 0);
            chk($sformatf("v%0d_read_data", i), mem_read_data, 0);
            chk($sformatf("v%0d_req", i), dmem_req, 0);
            chk($sformatf("v%0d_addr", i), dmem_addr, 0);
            chk($sformatf("v%0d_fault", i), mem_fault, 0);
        end

        // Load 0x0040 -> rd 3, ack in the 2nd REQ cycle with 0xBEEF.
        do_reset();
        set_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 3'd3);
        @(negedge clk);
        chk("ld_c0_stall", mem_stall, 1);
        chk("ld_c0_req", dmem_req, 0);
        next_cycle();
        @(negedge clk);
        chk("ld_c1_req", dmem_req, 1);
        chk("ld_c1_we", dmem_we, 0);
        chk("ld_c1_addr", dmem_addr, 16'h0040);
        chk("ld_c1_stall", mem_stall, 1);
        chk("ld_c1_reg_write", mem_reg_write, 0);
        next_cycle();
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hBEEF;
        @(negedge clk);
        chk("ld_c2_req", dmem_req, 1);
        chk("ld_c2_stall", mem_stall, 1);
        next_cycle();
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        @(negedge clk);
        chk("ld_resp_stall", mem_stall, 0);
        chk("ld_resp_data", mem_read_data, 16'hBEEF);
        chk("ld_resp_mem_read", mem_mem_read, 1);
        chk("ld_resp_reg_write", mem_reg_write, 1);
        chk("ld_resp_rd", mem_rd, 3);
        chk("ld_resp_alu", mem_alu_result, 16'h0040);
        chk("ld_resp_fault", mem_fault, 0);
        chk("ld_resp_req", dmem_req, 0);
        next_cycle();
        @(negedge clk);
        chk("ld_after_reg_write", mem_reg_write, 0);
        chk("ld_after_data", mem_read_data, 0);

        // Store 0x00AA to 0x0010, same-cycle ack; reg_write on input ignored.
        do_reset();
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h00AA, 3'd4);
        @(negedge clk);
        chk("st_c0_stall", mem_stall, 1);
        next_cycle();
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h5A5A;
        @(negedge clk);
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 16'h0010);
        chk("st_wdata", dmem_wdata, 16'h00AA);
        next_cycle();
        dmem_ack = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        @(negedge clk);
        chk("st_resp_stall", mem_stall, 0);
        chk("st_resp_reg_write", mem_reg_write, 0);
        chk("st_resp_mem_read", mem_mem_read, 0);
        chk("st_resp_data", mem_read_data, 0);
        chk("st_resp_we", dmem_we, 0);
        chk("st_resp_wdata", dmem_wdata, 0);

        // Load with no ack: request must stay up exactly 15 cycles.
        do_reset();
        dmem_rdata = 16'hDEAD;
        set_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 3'd6);
        next_cycle();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dmem_req) break;
            n++;
            next_cycle();
        end
        chk("to_req_cycles", n, 15);
        chk("to_fault", mem_fault, 1);
        chk("to_reg_write", mem_reg_write, 0);
        chk("to_mem_read", mem_mem_read, 0);
        chk("to_data", mem_read_data, 0);
        chk("to_rd", mem_rd, 6);
        chk("to_stall", mem_stall, 0);
        next_cycle();
        dmem_rdata = 16'h0;
        @(negedge clk);
        chk("to_fault_pulse", mem_fault, 0);

        // Reset in the 2nd REQ cycle, ack one cycle later.
        do_reset();
        set_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 3'd2);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        @(negedge clk);
        chk("rq_rst_req", dmem_req, 0);
        chk("rq_rst_stall", mem_stall, 0);
        chk("rq_rst_addr", dmem_addr, 0);
        next_cycle();
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h7777;
        @(negedge clk);
        chk("rq_ack_req", dmem_req, 0);
        chk("rq_ack_stall", mem_stall, 0);
        chk("rq_ack_data", mem_read_data, 0);
        next_cycle();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("rq_post_data", mem_read_data, 0);
        chk("rq_post_mem_read", mem_mem_read, 0);
        chk("rq_post_reg_write", mem_reg_write, 0);

        // Read and write both set: treated as a load.
        do_reset();
        set_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0099, 3'd2);
        next_cycle();
        dmem_ack   = 1'b1;
        dmem_rdata = 16'h1357;
        @(negedge clk);
        chk("rw_we", dmem_we, 0);
        chk("rw_addr", dmem_addr, 16'h0020);
        next_cycle();
        dmem_ack = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
        @(negedge clk);
        chk("rw_mem_read", mem_mem_read, 1);
        chk("rw_data", mem_read_data, 16'h1357);
        chk("rw_reg_write", mem_reg_write, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_access_stage
`default_nettype wire
